// File: rtl/rv32i_pkg.sv
// Shared RV32I register-file constants and the writeback requester encoding.
package rv32i_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } req_e;

endpackage

// File: rtl/wb_rr_arb.sv
// Two-input round-robin arbiter for the shared RegFile write port.
module wb_rr_arb
  import rv32i_pkg::*;
(
  input  logic alu_valid,
  input  logic lsu_valid,
  input  req_e ptr,
  output logic alu_gnt,
  output logic lsu_gnt,
  output req_e ptr_nxt
);

  always_comb begin
    alu_gnt = 1'b0;
    lsu_gnt = 1'b0;
    ptr_nxt = ptr;
    if (alu_valid && lsu_valid) begin
      // Contention: pointer side wins, pointer moves to the loser.
      if (ptr == REQ_ALU) begin
        alu_gnt = 1'b1;
        ptr_nxt = REQ_LSU;
      end else begin
        lsu_gnt = 1'b1;
        ptr_nxt = REQ_ALU;
      end
    end else begin
      alu_gnt = alu_valid;
      lsu_gnt = lsu_valid;
    end
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Writeback scheduler: arbitrates ALU/LSU onto the single RegFile write port
// and tracks pending destination writes for RAW/WAW hazard detection.
module regfile_wb_sched
  import rv32i_pkg::req_e, rv32i_pkg::REQ_ALU, rv32i_pkg::REQ_LSU;
#(
  parameter int unsigned XLEN = rv32i_pkg::XLEN,
  parameter int unsigned NREG = rv32i_pkg::NREG,
  parameter int unsigned AW   = rv32i_pkg::AW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  output logic            iss_ready,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic            raw_hazard,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            lsu_valid,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  output logic            wr_en,
  output logic [31:0]     WriteAddr,
  output logic [XLEN-1:0] WriteData,
  output logic            wb_err
);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  req_e            ptr;
  req_e            ptr_nxt;
  logic            alu_gnt;
  logic            lsu_gnt;
  logic            g_valid;
  logic [AW-1:0]   g_rd;
  logic [XLEN-1:0] g_data;
  logic            g_wr;
  logic            iss_fire;

  wb_rr_arb u_arb (
    .alu_valid (alu_valid),
    .lsu_valid (lsu_valid),
    .ptr       (ptr),
    .alu_gnt   (alu_gnt),
    .lsu_gnt   (lsu_gnt),
    .ptr_nxt   (ptr_nxt)
  );

  assign alu_ready = alu_gnt;
  assign lsu_ready = lsu_gnt;

  assign g_valid = alu_gnt | lsu_gnt;
  assign g_rd    = alu_gnt ? alu_rd   : lsu_rd;
  assign g_data  = alu_gnt ? alu_data : lsu_data;
  assign g_wr    = g_valid && (g_rd != '0);

  // Hazard outputs look only at registered busy: no bypass from this cycle's grant.
  assign iss_ready  = (iss_rd == '0) || !busy[iss_rd];
  assign raw_hazard = ((rs1_addr != '0) && busy[rs1_addr]) ||
                      ((rs2_addr != '0) && busy[rs2_addr]);
  assign iss_fire   = iss_valid && iss_ready && (iss_rd != '0);

  // Clear first, then set, so a same-edge issue to the written register stays busy.
  always_comb begin
    busy_nxt = busy;
    if (g_wr) begin
      busy_nxt[g_rd] = 1'b0;
    end
    if (iss_fire) begin
      busy_nxt[iss_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy      <= '0;
      ptr       <= REQ_ALU;
      wr_en     <= 1'b0;
      WriteAddr <= '0;
      WriteData <= '0;
      wb_err    <= 1'b0;
    end else begin
      busy  <= busy_nxt;
      ptr   <= ptr_nxt;
      wr_en <= g_wr;
      if (g_wr) begin
        WriteAddr <= {{(32-AW){1'b0}}, g_rd};
        WriteData <= g_data;
        if (!busy[g_rd]) begin
          wb_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Scoreboard bench for regfile_wb_sched: directed issue/writeback vectors,
// expected RegFile writes queued at grant time and checked by a write monitor.
module tb_regfile_wb_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        raw_hazard;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic        wr_en;
  logic [31:0] WriteAddr;
  logic [31:0] WriteData;
  logic        wb_err;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  regfile_wb_sched #(.XLEN(32), .NREG(32), .AW(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .iss_valid  (iss_valid),
    .iss_rd     (iss_rd),
    .iss_ready  (iss_ready),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .raw_hazard (raw_hazard),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .alu_ready  (alu_ready),
    .lsu_valid  (lsu_valid),
    .lsu_rd     (lsu_rd),
    .lsu_data   (lsu_data),
    .lsu_ready  (lsu_ready),
    .wr_en      (wr_en),
    .WriteAddr  (WriteAddr),
    .WriteData  (WriteData),
    .wb_err     (wb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  // Write monitor: every registered write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected no write at %0t",
                 WriteAddr, WriteData, $time);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        chk("wr_addr", WriteAddr, w.addr);
        chk("wr_data", WriteData, w.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic issue(input logic [4:0] rd);
    iss_valid = 1'b1;
    iss_rd    = rd;
    tick();
    iss_valid = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    iss_valid = 1'b1; iss_rd = '0;
    rs1_addr  = '0;   rs2_addr = '0;
    alu_valid = 1'b1; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b1; lsu_rd = '0; lsu_data = '0;
    tick(); tick();
    chk("rst_wr_en", wr_en, 0);
    chk("rst_addr", WriteAddr, 0);
    chk("rst_data", WriteData, 0);
    chk("rst_wb_err", wb_err, 0);
    chk("rst_iss_ready", iss_ready, 1);
    chk("rst_raw", raw_hazard, 0);
    iss_valid = 1'b0; alu_valid = 1'b0; lsu_valid = 1'b0;
    reset = 1'b1;
    tick();

    // Issue rd=5, then hazards on it
    issue(5'd5);
    rs1_addr = 5'd5; iss_rd = 5'd5;
    #1;
    chk("raw_rd5", raw_hazard, 1);
    chk("waw_rd5", iss_ready, 0);
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h14;
    #1;
    chk("alu_gnt_rd5", alu_ready, 1);
    chk("lsu_nogrant_rd5", lsu_ready, 0);
    chk("raw_no_bypass", raw_hazard, 1);
    chk("waw_no_bypass", iss_ready, 0);
    expect_wr(32'd5, 32'h14);
    tick();
    alu_valid = 1'b0;
    #1;
    chk("raw_cleared", raw_hazard, 0);
    chk("waw_cleared", iss_ready, 1);
    chk("wb_err_clean", wb_err, 0);
    rs1_addr = '0;

    // Contention, pointer starts at ALU
    issue(5'd1);
    issue(5'd2);
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1E;
    lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h28;
    #1;
    chk("cont1_alu", alu_ready, 1);
    chk("cont1_lsu", lsu_ready, 0);
    expect_wr(32'd1, 32'h1E);
    tick();
    alu_valid = 1'b0;
    #1;
    chk("cont1b_lsu", lsu_ready, 1);
    chk("cont1b_alu", alu_ready, 0);
    expect_wr(32'd2, 32'h28);
    tick();
    lsu_valid = 1'b0;

    // Second contention: LSU wins
    issue(5'd8);
    issue(5'd9);
    alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'h11;
    lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h22;
    #1;
    chk("cont2_lsu", lsu_ready, 1);
    chk("cont2_alu", alu_ready, 0);
    expect_wr(32'd9, 32'h22);
    tick();
    lsu_valid = 1'b0;
    #1;
    chk("cont2b_alu", alu_ready, 1);
    expect_wr(32'd8, 32'h11);
    tick();
    alu_valid = 1'b0;

    // x0 writeback: granted, no write, no error
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEADBEEF;
    iss_rd = 5'd0;
    #1;
    chk("x0_alu_ready", alu_ready, 1);
    chk("x0_iss_ready", iss_ready, 1);
    tick();
    alu_valid = 1'b0;
    #1;
    chk("x0_wr_en", wr_en, 0);
    chk("x0_wb_err", wb_err, 0);

    // Writeback to non-busy register 7 flags wb_err but still writes
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h77;
    #1;
    chk("err_lsu_ready", lsu_ready, 1);
    expect_wr(32'd7, 32'h77);
    tick();
    lsu_valid = 1'b0;
    #1;
    chk("wb_err_set", wb_err, 1);

    // Same-edge issue and grant on rd=3: set wins
    iss_valid = 1'b1; iss_rd = 5'd3;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
    #1;
    chk("same_iss_ready", iss_ready, 1);
    chk("same_alu_ready", alu_ready, 1);
    expect_wr(32'd3, 32'h33);
    tick();
    iss_valid = 1'b0; alu_valid = 1'b0;
    rs2_addr = 5'd3;
    #1;
    chk("same_busy_raw", raw_hazard, 1);
    chk("same_busy_waw", iss_ready, 0);
    chk("wb_err_sticky", wb_err, 1);
    rs2_addr = '0;

    // Async reset while a write is in flight
    issue(5'd4);
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44;
    @(posedge clk);
    #1;
    alu_valid = 1'b0;
    chk("inflight_wr_en", wr_en, 1);
    #1;
    reset = 1'b0;
    #1;
    chk("async_wr_en", wr_en, 0);
    chk("async_addr", WriteAddr, 0);
    chk("async_wb_err", wb_err, 0);
    iss_rd = 5'd4; rs1_addr = 5'd4; rs2_addr = 5'd3;
    #1;
    chk("async_busy_waw", iss_ready, 1);
    chk("async_busy_raw", raw_hazard, 0);
    tick();
    reset = 1'b1;
    rs1_addr = '0; rs2_addr = '0; iss_rd = '0;
    tick(); tick();

    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
